// File: rtl/r4u4_twiddle_mul_pkg.sv
// Shared constants and types for radix-4 FFT unit-4 twiddle multiply.
// Coefficients are Q2.(CW-2); the ROM address is the in-block sample index.
package r4u4_twiddle_mul_pkg;

  localparam int COEF_WIDTH = 16;
  localparam int BLK_LEN    = 512;
  localparam int ADDR_W     = 9;
  localparam int RND_SHIFT  = COEF_WIDTH - 2;

  typedef struct packed {
    logic valid;
    logic sop;
    logic eop;
  } tag_t;

endpackage

// File: rtl/r4u4_twiddle_mul_cmul_rnd.sv
// Pipelined complex multiply with round-half-up and saturation.
// Three register stages: products, round/shift, saturate.
module cmul_rnd
  import r4u4_twiddle_mul_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = COEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic signed [CW-1:0] coef_re,
  input  logic signed [CW-1:0] coef_im,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [DW-1:0]        out_re,
  output logic [DW-1:0]        out_im,
  output logic                 out_ovf
);

  localparam int PW = DW + CW;
  localparam int XW = PW + 1;
  localparam int SH = CW - 2;

  localparam logic signed [XW-1:0] RND =
    XW'(1) <<< (CW - 3);
  localparam logic signed [XW-1:0] SMAX =
    (XW'(1) <<< (DW - 1)) - XW'(1);
  localparam logic signed [XW-1:0] SMIN = ~SMAX;
  localparam logic [DW-1:0] DMAX =
    {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DMIN =
    {1'b1, {(DW-1){1'b0}}};

  tag_t t2, t3;

  logic signed [PW-1:0] p_ac, p_bd;
  logic signed [PW-1:0] p_ad, p_bc;
  logic signed [XW-1:0] sum_re, sum_im;
  logic signed [XW-1:0] r3, i3;
  logic                 hi_re, lo_re;
  logic                 hi_im, lo_im;

  assign sum_re = p_ac - p_bd;
  assign sum_im = p_ad + p_bc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t2   <= '0;
      p_ac <= '0;
      p_bd <= '0;
      p_ad <= '0;
      p_bc <= '0;
    end else begin
      t2   <= '{in_valid, in_sop, in_eop};
      p_ac <= in_re * coef_re;
      p_bd <= in_im * coef_im;
      p_ad <= in_re * coef_im;
      p_bc <= in_im * coef_re;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t3 <= '0;
      r3 <= '0;
      i3 <= '0;
    end else begin
      t3 <= t2;
      r3 <= (sum_re + RND) >>> SH;
      i3 <= (sum_im + RND) >>> SH;
    end
  end

  assign hi_re = r3 > SMAX;
  assign lo_re = r3 < SMIN;
  assign hi_im = i3 > SMAX;
  assign lo_im = i3 < SMIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_ovf   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= t3.valid;
      out_sop   <= t3.valid & t3.sop;
      out_eop   <= t3.valid & t3.eop;
      out_ovf   <= t3.valid &
                   (hi_re | lo_re | hi_im | lo_im);
      out_re    <= hi_re ? DMAX :
                   lo_re ? DMIN : r3[DW-1:0];
      out_im    <= hi_im ? DMAX :
                   lo_im ? DMIN : i3[DW-1:0];
    end
  end

endmodule

// File: rtl/r4u4_twiddle_mul.sv
// FFT unit-4 twiddle stage: sample counter drives ROM address,
// stage 1 captures sample and coefficient, cmul_rnd does the rest.
module r4u4_twiddle_mul
  import r4u4_twiddle_mul_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = COEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [2*CW-1:0]      rom_data,
  output logic                 out_valid,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [DW-1:0]        out_re,
  output logic [DW-1:0]        out_im,
  output logic                 out_ovf
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(BLK_LEN - 1);

  logic [ADDR_W-1:0] cnt, idx;

  tag_t                 t1;
  logic signed [DW-1:0] s1_re, s1_im;
  logic signed [CW-1:0] s1_cre, s1_cim;

  // sop forces index 0 even when the counter is mid-block
  assign idx      = in_sop ? '0 : cnt;
  assign rom_addr = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (in_valid)
      cnt <= idx + ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1     <= '0;
      s1_re  <= '0;
      s1_im  <= '0;
      s1_cre <= '0;
      s1_cim <= '0;
    end else begin
      t1     <= '{in_valid,
                  in_valid & in_sop,
                  in_valid & (idx == LAST)};
      s1_re  <= in_re;
      s1_im  <= in_im;
      s1_cre <= rom_data[2*CW-1:CW];
      s1_cim <= rom_data[CW-1:0];
    end
  end

  cmul_rnd #(
    .DW (DW),
    .CW (CW)
  ) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (t1.valid),
    .in_sop    (t1.sop),
    .in_eop    (t1.eop),
    .in_re     (s1_re),
    .in_im     (s1_im),
    .coef_re   (s1_cre),
    .coef_im   (s1_cim),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_ovf   (out_ovf)
  );

endmodule
